// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multi-port register file (regfile_mp).
//   - state_e     : clear-sweep FSM states (IDLE, CLEAR)
//   - DATA_W_DEF  : default register width
//   - ADDR_W_DEF  : default address width (DEPTH = 2**ADDR_W)
//   - bus_slice() : extracts field k of width w from a packed port bus
// Optional feature macro used by this block: REGFILE_ZERO_REG_EN
// -----------------------------------------------------------------------------
package regfile_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Upper bounds for the generic slicing helper. Callers zero-extend their
    // packed bus to SLICE_BUS_W and truncate the result to their field width.
    localparam int SLICE_BUS_W = 256;
    localparam int SLICE_MAX_W = 64;

    function automatic logic [SLICE_MAX_W-1:0] bus_slice(
        input logic [SLICE_BUS_W-1:0] bus,
        input int                     k,
        input int                     w
    );
        logic [SLICE_BUS_W-1:0] shifted;
        logic [SLICE_MAX_W-1:0] mask;
        shifted = bus >> (k * w);
        if (w >= SLICE_MAX_W) begin
            mask = '1;
        end else begin
            mask = (SLICE_MAX_W'(1) << w) - SLICE_MAX_W'(1);
        end
        return shifted[SLICE_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// -----------------------------------------------------------------------------
// regfile_mp_if
// Bundle of the register-file port signals.
//   clr_req     : pulse, starts a soft clear sweep (honoured only in IDLE)
//   we          : per-write-port enable           [NUM_WR]
//   waddr/wdata : packed write address/data, port k at [k*W +: W]
//   raddr/rdata : packed read address/data, port j at [j*W +: W]
//   busy/ready  : clear sweep in progress / ~busy
//   dbg_state   : clear FSM state (0 = IDLE, 1 = CLEAR)
//   dbg_clr_idx : entry the sweep clears on the next edge
// Handshake: a write on port k is accepted on a rising edge exactly when
// we[k] and ready are both high on that edge; with ready low the write is
// dropped, never queued. rdata is combinational and has no valid qualifier.
// -----------------------------------------------------------------------------
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    logic                     clr_req;
    logic [NUM_WR-1:0]        we;
    logic [NUM_WR*ADDR_W-1:0] waddr;
    logic [NUM_WR*DATA_W-1:0] wdata;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic                     busy;
    logic                     ready;
    logic                     dbg_state;
    logic [ADDR_W-1:0]        dbg_clr_idx;

    modport master (
        output clr_req, we, waddr, wdata, raddr,
        input  rdata, busy, ready, dbg_state, dbg_clr_idx
    );

    modport slave (
        input  clr_req, we, waddr, wdata, raddr,
        output rdata, busy, ready, dbg_state, dbg_clr_idx
    );
endinterface

// File: rtl/regfile_clr_fsm.sv
// -----------------------------------------------------------------------------
// regfile_clr_fsm
// Owns the clear-sweep state machine for regfile_mp.
//   clk, rst       : clock, synchronous active-high reset
//   clr_req_i      : soft clear request (ignored while already clearing)
//   busy_o         : sweep in progress
//   clr_en_o       : write zero to clr_addr_o on this edge
//   clr_addr_o     : entry being cleared
//   state_o        : current state (debug)
// Reset enters CLEAR at index 0 without clearing anything on the reset edge;
// each following edge clears one entry, and the edge that clears the last
// entry returns to IDLE, so busy stays high for exactly DEPTH edges.
// -----------------------------------------------------------------------------
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req_i,
    output logic              busy_o,
    output logic              clr_en_o,
    output logic [ADDR_W-1:0] clr_addr_o,
    output logic [0:0]        state_o
);

    localparam logic [0:0] S_IDLE  = ST_IDLE;
    localparam logic [0:0] S_CLEAR = ST_CLEAR;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            S_IDLE: begin
                if (clr_req_i) begin
                    state_d   = S_CLEAR;
                    clr_idx_d = '0;
                end
            end
            S_CLEAR: begin
                // The index never overflows: the last entry exits the sweep.
                if (&clr_idx_q) begin
                    state_d   = S_IDLE;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d   = S_CLEAR;
                clr_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    assign busy_o     = (state_q == S_CLEAR);
    // No entry is cleared on a reset edge.
    assign clr_en_o   = (state_q == S_CLEAR) && !rst;
    assign clr_addr_o = clr_idx_q;
    assign state_o    = state_q;

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-port register file with write priority, optional
// write-to-read bypass and a sequential clear sweep.
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset, starts a clear sweep
//   bus  : regfile_mp_if.slave (clr_req, we, waddr, wdata, raddr, rdata,
//          busy, ready, dbg_state, dbg_clr_idx)
// Parameters: DATA_W, ADDR_W (DEPTH = 2**ADDR_W), NUM_RD (1..4),
//             NUM_WR (1..2), BYPASS (1 = forward same-cycle write data).
// Optional macro REGFILE_ZERO_REG_EN: entry 0 reads as zero and writes to
// address 0 are dropped (also ignored by bypass and write priority).
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_W;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Clear sweep control
    // ---------------------------------------------------------------------
    logic              busy;
    logic              ready;
    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic [0:0]        fsm_state;

    regfile_clr_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clr_fsm (
        .clk        (clk),
        .rst        (rst),
        .clr_req_i  (bus.clr_req),
        .busy_o     (busy),
        .clr_en_o   (clr_en),
        .clr_addr_o (clr_addr),
        .state_o    (fsm_state)
    );

    assign ready           = ~busy;
    assign bus.busy        = busy;
    assign bus.ready       = ready;
    assign bus.dbg_state   = fsm_state[0];
    assign bus.dbg_clr_idx = clr_addr;

    // ---------------------------------------------------------------------
    // Unpack port buses
    // ---------------------------------------------------------------------
    logic [SLICE_BUS_W-1:0] waddr_ext;
    logic [SLICE_BUS_W-1:0] wdata_ext;
    logic [SLICE_BUS_W-1:0] raddr_ext;

    assign waddr_ext = SLICE_BUS_W'(bus.waddr);
    assign wdata_ext = SLICE_BUS_W'(bus.wdata);
    assign raddr_ext = SLICE_BUS_W'(bus.raddr);

    logic [ADDR_W-1:0] waddr_a [NUM_WR];
    logic [DATA_W-1:0] wdata_a [NUM_WR];
    logic [ADDR_W-1:0] raddr_a [NUM_RD];
    logic [NUM_WR-1:0] wr_en;

    for (genvar k = 0; k < NUM_WR; k++) begin : g_wr_unpack
        assign waddr_a[k] = ADDR_W'(bus_slice(waddr_ext, k, ADDR_W));
        assign wdata_a[k] = DATA_W'(bus_slice(wdata_ext, k, DATA_W));
        // A write is live only when the file is idle and not being reset;
        // with the zero register, address 0 writes vanish here so they take
        // part in neither storage, priority nor bypass.
        assign wr_en[k]   = bus.we[k] && ready && !rst &&
                            !(ZERO_REG && (waddr_a[k] == '0));
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd_unpack
        assign raddr_a[j] = ADDR_W'(bus_slice(raddr_ext, j, ADDR_W));
    end

    // ---------------------------------------------------------------------
    // Storage (no reset; contents are defined by the clear sweep)
    // ---------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem_q[clr_addr] <= '0;
        end else begin
            // Later iterations override earlier ones: the higher port wins
            // when two enabled ports target the same address.
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en[k]) begin
                    mem_q[waddr_a[k]] <= wdata_a[k];
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Read ports
    // ---------------------------------------------------------------------
    logic [DATA_W-1:0] rd_val [NUM_RD];

    always_comb begin
        for (int j = 0; j < NUM_RD; j++) begin
            rd_val[j] = mem_q[raddr_a[j]];
            if (BYPASS != 0) begin
                // Highest matching write port provides the forwarded value.
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wr_en[k] && (waddr_a[k] == raddr_a[j])) begin
                        rd_val[j] = wdata_a[k];
                    end
                end
            end
            if (ZERO_REG && (raddr_a[j] == '0)) begin
                rd_val[j] = '0;
            end
            if (busy) begin
                rd_val[j] = '0;
            end
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd_pack
        assign bus.rdata[j*DATA_W +: DATA_W] = rd_val[j];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Two DUT instances share all stimulus: dut_b (BYPASS=1) and dut_n (BYPASS=0).
// Directed vectors push hand-computed expectations into a queue; a monitor on
// the falling edge pops and compares them against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) if_b ();
  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) if_n ();

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0)) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (if_n)
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int            sel_q[$];
  string         name_q[$];
  int            tests_run;
  int            tests_failed;

  function automatic logic [DW-1:0] actual(input int sel);
    case (sel)
      0: return if_b.rdata[0 +: DW];
      1: return if_b.rdata[DW +: DW];
      2: return if_n.rdata[0 +: DW];
      3: return if_n.rdata[DW +: DW];
      4: return DW'(if_b.busy);
      5: return DW'(if_b.ready);
      6: return DW'(if_n.busy);
      7: return DW'(if_n.ready);
      8: return DW'(if_b.dbg_clr_idx);
      default: return '1;
    endcase
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [DW-1:0] e;
      logic [DW-1:0] a;
      int            s;
      string         nm;
      e  = exp_q.pop_front();
      s  = sel_q.pop_front();
      nm = name_q.pop_front();
      a  = actual(s);
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL %s (sel %0d): got %h expected %h", nm, s, a, e);
      end
    end
  end

  task automatic push(input int sel, input logic [DW-1:0] val, input string nm);
    exp_q.push_back(val);
    sel_q.push_back(sel);
    name_q.push_back(nm);
  endtask

  task automatic check_now(input logic [DW-1:0] a, input logic [DW-1:0] e,
                           input string nm);
    tests_run++;
    if (a !== e) begin
      tests_failed++;
      $display("FAIL %s (immediate): got %h expected %h", nm, a, e);
    end
  endtask

  // Read port j: expected value on the bypass DUT and on the no-bypass DUT.
  task automatic exp_rd(input int j, input logic [DW-1:0] vb,
                        input logic [DW-1:0] vn, input string nm);
    push(j, vb, {nm, "_byp"});
    push(2 + j, vn, {nm, "_nobyp"});
  endtask

  task automatic exp_status(input logic b, input string nm);
    push(4, DW'(b), {nm, "_busy_b"});
    push(5, DW'(!b), {nm, "_ready_b"});
    push(6, DW'(b), {nm, "_busy_n"});
    push(7, DW'(!b), {nm, "_ready_n"});
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max_edges, input string nm);
    int n;
    n = 0;
    while ((if_b.busy || if_n.busy) && (n < max_edges)) begin
      step();
      n++;
    end
    tests_run++;
    if (if_b.busy || if_n.busy) begin
      tests_failed++;
      $display("FAIL %s: busy still high after %0d edges", nm, max_edges);
    end
  endtask

  task automatic drive(input logic cr, input logic [NW-1:0] we,
                       input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                       input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
                       input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    if_b.clr_req = cr;         if_n.clr_req = cr;
    if_b.we      = we;         if_n.we      = we;
    if_b.waddr   = {wa1, wa0}; if_n.waddr   = {wa1, wa0};
    if_b.wdata   = {wd1, wd0}; if_n.wdata   = {wd1, wd0};
    if_b.raddr   = {ra1, ra0}; if_n.raddr   = {ra1, ra0};
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    drive(1'b0, 2'b00, 5'd0, 5'd0, '0, '0, 5'd0, 5'd0);

    // Reset edge: sweep armed, outputs forced to zero.
    step();
    exp_status(1'b1, "rst");
    exp_rd(0, '0, '0, "rst_rdata0");
    check_now(DW'(if_b.busy), DW'(1), "rst_state_busy_b");
    check_now(DW'(if_b.ready), DW'(0), "rst_state_ready_b");
    check_now(DW'(if_n.busy), DW'(1), "rst_state_busy_n");
    check_now(if_b.rdata, '0, "rst_state_rdata_b");
    check_now(if_n.rdata, '0, "rst_state_rdata_n");
    rst = 1'b0;

    // Busy for exactly 32 edges after reset falls.
    for (int k = 1; k <= 32; k++) begin
      step();
      exp_status((k < 32) ? 1'b1 : 1'b0, "rst_sweep");
    end
    wait_idle(40, "rst_sweep_wait");

    // Every entry reads zero after the sweep.
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 2'b00, 5'd0, 5'd0, '0, '0, AW'(a), AW'(31 - a));
      exp_rd(0, '0, '0, "swept_rd0");
      exp_rd(1, '0, '0, "swept_rd1");
      step();
    end

    // Both ports write r5: port 1 wins.
    drive(1'b0, 2'b11, 5'd5, 5'd5, 32'hAAAA_0000, 32'h5555_1111, 5'd9, 5'd5);
    exp_rd(0, '0, '0, "dual_r9");
    exp_rd(1, 32'h5555_1111, '0, "dual_same_cycle");
    step();
    drive(1'b0, 2'b00, 5'd0, 5'd0, '0, '0, 5'd5, 5'd9);
    exp_rd(0, 32'h5555_1111, 32'h5555_1111, "dual_next");
    exp_rd(1, '0, '0, "dual_r9_next");
    step();

    // Bypass on r7.
    drive(1'b0, 2'b01, 5'd7, 5'd0, 32'h1234_5678, '0, 5'd7, 5'd0);
    exp_rd(0, 32'h1234_5678, '0, "bypass_r7");
    step();
    drive(1'b0, 2'b00, 5'd0, 5'd0, '0, '0, 5'd7, 5'd0);
    exp_rd(0, 32'h1234_5678, 32'h1234_5678, "bypass_r7_next");
    step();

    // Distinct addresses on both ports, crossed reads, top entry.
    drive(1'b0, 2'b11, 5'd10, 5'd31, 32'h0A0A_0A0A, 32'h3131_3131, 5'd31, 5'd10);
    exp_rd(0, 32'h3131_3131, '0, "cross_r31");
    exp_rd(1, 32'h0A0A_0A0A, '0, "cross_r10");
    step();
    drive(1'b0, 2'b00, 5'd0, 5'd0, '0, '0, 5'd31, 5'd10);
    exp_rd(0, 32'h3131_3131, 32'h3131_3131, "cross_r31_next");
    exp_rd(1, 32'h0A0A_0A0A, 32'h0A0A_0A0A, "cross_r10_next");
    step();

    // Write all-ones to r0.
    drive(1'b0, 2'b01, 5'd0, 5'd0, 32'hFFFF_FFFF, '0, 5'd0, 5'd0);
    exp_rd(0, ZR ? 32'h0 : 32'hFFFF_FFFF, '0, "r0_same");
    step();
    drive(1'b0, 2'b00, 5'd0, 5'd0, '0, '0, 5'd0, 5'd0);
    exp_rd(0, ZR ? 32'h0 : 32'hFFFF_FFFF, ZR ? 32'h0 : 32'hFFFF_FFFF, "r0_next");
    step();

    // Port 1 writing r0 must not mask port 0 writing r12.
    drive(1'b0, 2'b11, 5'd12, 5'd0, 32'h1212_1212, 32'h9999_9999, 5'd12, 5'd0);
    exp_rd(0, 32'h1212_1212, '0, "mask_r12");
    exp_rd(1, ZR ? 32'h0 : 32'h9999_9999, ZR ? 32'h0 : 32'hFFFF_FFFF, "mask_r0");
    step();
    drive(1'b0, 2'b00, 5'd0, 5'd0, '0, '0, 5'd12, 5'd0);
    exp_rd(0, 32'h1212_1212, 32'h1212_1212, "mask_r12_next");
    exp_rd(1, ZR ? 32'h0 : 32'h9999_9999, ZR ? 32'h0 : 32'h9999_9999, "mask_r0_next");
    step();

    // Prefill r25, then request a soft clear.
    drive(1'b0, 2'b01, 5'd25, 5'd0, 32'h2525_2525, '0, 5'd25, 5'd0);
    exp_rd(0, 32'h2525_2525, '0, "prefill_r25");
    step();
    drive(1'b1, 2'b00, 5'd0, 5'd0, '0, '0, 5'd25, 5'd5);
    exp_status(1'b0, "clr_req_idle");
    exp_rd(0, 32'h2525_2525, 32'h2525_2525, "prefill_r25_next");
    step();

    // Sweep with a write to r3 held throughout: every write is dropped.
    for (int k = 0; k < 32; k++) begin
      drive(1'b0, 2'b01, 5'd3, 5'd0, 32'hDEAD_BEEF, '0, 5'd5, 5'd3);
      exp_status(1'b1, "soft_sweep");
      exp_rd(0, '0, '0, "soft_sweep_rd0");
      exp_rd(1, '0, '0, "soft_sweep_rd1");
      step();
    end
    wait_idle(4, "soft_sweep_wait");
    drive(1'b0, 2'b00, 5'd0, 5'd0, '0, '0, 5'd3, 5'd25);
    exp_status(1'b0, "soft_done");
    exp_rd(0, '0, '0, "dropped_r3");
    exp_rd(1, '0, '0, "cleared_r25");
    step();
    drive(1'b0, 2'b00, 5'd0, 5'd0, '0, '0, 5'd12, 5'd7);
    exp_rd(0, '0, '0, "cleared_r12");
    exp_rd(1, '0, '0, "cleared_r7");
    step();

    // Reset at clr_idx = 20 restarts the sweep.
    drive(1'b1, 2'b00, 5'd0, 5'd0, '0, '0, 5'd0, 5'd0);
    step();
    drive(1'b0, 2'b00, 5'd0, 5'd0, '0, '0, 5'd0, 5'd0);
    for (int k = 0; k < 20; k++) begin
      exp_status(1'b1, "mid_sweep");
      step();
    end
    push(8, 32'd20, "mid_idx20");
    rst = 1'b1;
    exp_status(1'b1, "mid_rst");
    step();
    rst = 1'b0;
    push(8, 32'd0, "mid_idx_restart");
    for (int k = 0; k < 32; k++) begin
      exp_status(1'b1, "restart_sweep");
      step();
    end
    exp_status(1'b0, "restart_done");
    step();
    wait_idle(4, "restart_wait");

    step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port successor to the single-write, dual-read CPU register file.
- Adds configurable width, depth and port counts, deterministic multi-port write priority, and optional write-to-read bypass.
- Adds a sequential clear sweep after reset or on request, with busy/ready status.
- Sits in ID stage of the pipeline: read ports feed operand latches, write ports driven from WB (and a second retire path).

Parameters:
- DATA_W, 32, bits per register
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..4)
- NUM_WR, 2, number of write ports (1..2)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored array only

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- clr_req  in  1  pulse: start soft clear sweep (honoured only in IDLE)
- we  in  NUM_WR  per-port write enable
- waddr  in  NUM_WR*ADDR_W  write addresses, port k at bits [k*ADDR_W +: ADDR_W]
- wdata  in  NUM_WR*DATA_W  write data, port k at bits [k*DATA_W +: DATA_W]
- raddr  in  NUM_RD*ADDR_W  read addresses, same packing
- rdata  out  NUM_RD*DATA_W  read data, combinational, same packing
- busy  out  1  clear sweep in progress
- ready  out  1  equals ~busy; writes are accepted only when high

Behaviour:
- States: IDLE, CLEAR. Counter clr_idx (ADDR_W bits).
- rst high on a clock edge:
  - state<=CLEAR, clr_idx<=0; busy=1, ready=0.
  - No array entry is written on that edge; the array itself has no reset.
- CLEAR, rst low: each edge writes 0 to entry clr_idx and increments clr_idx. On the edge that clears entry DEPTH-1, state<=IDLE.
  - busy falls exactly DEPTH edges after the first edge with rst low.
- IDLE with clr_req=1: state<=CLEAR, clr_idx<=0, same sweep. clr_req is ignored while in CLEAR.
- rst mid-sweep: sweep restarts at clr_idx=0.
- Writes:
  - In IDLE, each port with we[k]=1 writes wdata[k] to waddr[k] on the edge.
  - In CLEAR, all we are ignored (dropped, no queueing).
- Write conflict: two ports, same address, both enabled -> higher port index wins; the lower port's data is discarded.
- Reads:
  - Combinational from array; all NUM_RD ports are independent; any port may read any address.
  - While busy=1, every rdata returns 0.
- Bypass (BYPASS=1, IDLE only): if raddr[j] matches an enabled waddr[k], rdata[j]=wdata[k], using the highest matching k. Otherwise the stored value.
- BYPASS=0: a read of an address written this cycle returns the old value; the new value is visible the next cycle.
- Widths: no arithmetic on data; clr_idx wraps only via the state exit, never by overflow.
- Outputs after reset: busy=1, ready=0, rdata=0 until sweep completes.

Optional Feature:
- Macro REGFILE_ZERO_REG_EN.
- Defined:
  - Entry 0 is hardwired zero: reads of address 0 always return 0.
  - Writes to address 0 are dropped and excluded from bypass and conflict resolution.
  - A write to 0 on port 1 does not mask port 0 writing another address.
- Undefined: entry 0 is ordinary storage.

Decomposition:
- Shared package regfile_pkg:
  - state enum (IDLE, CLEAR)
  - default DATA_W/ADDR_W constants
  - functions to slice packed port buses
- One sub-module regfile_clr_fsm: owns state, clr_idx, busy; outputs clear enable and clear address to the array.

Test Plan:
- Reset sweep: rst high 1 cycle, then low, DEPTH=32 -> busy high for exactly 32 edges after rst falls, then ready=1; every address reads 0.
- Dual write, same address: we=2'b11, waddr both 5, wdata0=0xAAAA_0000, wdata1=0x5555_1111 -> next cycle r5=0x5555_1111.
- Bypass:
  - BYPASS=1, write 0x1234_5678 to r7 while raddr0=7 -> same-cycle rdata0=0x1234_5678.
  - BYPASS=0 -> old value that cycle, new value next.
- Write during clear: clr_req in IDLE, then write 0xDEAD_BEEF to r3 during sweep -> write dropped; r3 reads 0 after busy falls.
- Reset mid-sweep: rst asserted at clr_idx=20 -> sweep restarts; busy stays high 32 more edges.
- REGFILE_ZERO_REG_EN defined: write 0xFFFF_FFFF to r0 with raddr0=0 -> rdata0=0 same and next cycle. Undefined -> 0xFFFF_FFFF next cycle.
